// File: rtl/minv_mdiv_seq_if.sv
// Host-side bus of the MINV_MDIV sequencer: operand request and result return.
//
// Handshake: the host raises start for one cycle with op_a/op_b/op_p/mode
// valid in that same cycle. The request is taken only while the sequencer is
// idle (busy=0 and done=0) and is silently dropped otherwise. busy is high from
// the cycle after an accepted start until the done cycle. done is a one-cycle
// pulse. res_x1/res_x2/res_flag are valid from done and are held until the
// next accepted start. timeout is meaningful only in the done cycle.
interface minv_mdiv_seq_if #(
    parameter int OP_W = 256
);
    logic            start;
    logic            mode;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic [OP_W-1:0] op_p;
    logic            busy;
    logic            done;
    logic            timeout;
    logic [OP_W-1:0] res_x1;
    logic [OP_W-1:0] res_x2;
    logic            res_flag;

    modport master (
        output start, mode, op_a, op_b, op_p,
        input  busy, done, timeout, res_x1, res_x2, res_flag
    );

    modport slave (
        input  start, mode, op_a, op_b, op_p,
        output busy, done, timeout, res_x1, res_x2, res_flag
    );
endinterface

// File: rtl/minv_mdiv_seq.sv
// Upstream sequencer for the MINV_MDIV engine. Streams a, p (and b in
// division mode) word-serially into the engine, pulses eng_en, waits for
// eng_rdy with a timeout, then reads x1/x2 back word-serially.
module minv_mdiv_seq #(
    parameter int WORD_W   = 16,
    parameter int N_WORDS  = 16,
    parameter int SETTLE   = 2,
    parameter int OUT_LAT  = 1,
    parameter int MAX_WAIT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    minv_mdiv_seq_if.slave    host,
    output logic [WORD_W-1:0] eng_datain,
    output logic              eng_loada,
    output logic              eng_loadp,
    output logic              eng_loadb,
    output logic              eng_en,
    output logic              eng_mode,
    output logic              eng_outx1,
    output logic              eng_outx2,
    input  logic [WORD_W-1:0] eng_x1,
    input  logic [WORD_W-1:0] eng_x2,
    input  logic              eng_rdy,
    input  logic              eng_flag,
    output logic [3:0]        o_dbg_state
);
    localparam int OP_W    = WORD_W * N_WORDS;
    localparam int RD_N    = N_WORDS + OUT_LAT;
    localparam int CNT_M1  = (MAX_WAIT > RD_N) ? MAX_WAIT : RD_N;
    localparam int CNT_MAX = (CNT_M1 > SETTLE) ? CNT_M1 : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LD_LAST    = CNT_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_N - 1);
    localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(OUT_LAT);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_P = 4'd2,
        S_LOAD_B = 4'd3,
        S_GO     = 4'd4,
        S_WAIT   = 4'd5,
        S_SETTLE = 4'd6,
        S_READ   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic [OP_W-1:0]  r_p;
    logic             r_mode;
    logic [OP_W-1:0]  r_res_x1;
    logic [OP_W-1:0]  r_res_x2;
    logic             r_res_flag;
    logic             r_timeout;
    logic [OP_W-1:0]  w_op;
    logic [OP_W-1:0]  w_op_sh;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && host.start;

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus engine strobes; the load word index is the shared counter.
    always_comb begin
        w_next     = r_state;
        w_op       = r_a;
        eng_loada  = 1'b0;
        eng_loadp  = 1'b0;
        eng_loadb  = 1'b0;
        eng_en     = 1'b0;
        eng_outx1  = 1'b0;
        eng_outx2  = 1'b0;
        case (r_state)
            S_IDLE:   if (host.start) w_next = S_LOAD_A;
            S_LOAD_A: begin
                eng_loada = 1'b1;
                w_op      = r_a;
                if (r_cnt == LD_LAST) w_next = S_LOAD_P;
            end
            S_LOAD_P: begin
                eng_loadp = 1'b1;
                w_op      = r_p;
                if (r_cnt == LD_LAST) w_next = r_mode ? S_GO : S_LOAD_B;
            end
            S_LOAD_B: begin
                eng_loadb = 1'b1;
                w_op      = r_b;
                if (r_cnt == LD_LAST) w_next = S_GO;
            end
            S_GO: begin
                eng_en = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_rdy)                 w_next = (SETTLE == 0) ? S_READ : S_SETTLE;
                else if (r_cnt == WAIT_LAST) w_next = S_DONE;
            end
            S_SETTLE: if (r_cnt == SET_LAST) w_next = S_READ;
            S_READ: begin
                eng_outx1 = 1'b1;
                eng_outx2 = 1'b1;
                if (r_cnt == RD_LAST) w_next = S_DONE;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        w_op_sh    = w_op >> (int'(r_cnt) * WORD_W);
        eng_datain = (eng_loada || eng_loadp || eng_loadb) ? w_op_sh[WORD_W-1:0] : '0;
    end

    // Phase counter: restarts at every state change, so each phase counts from 0.
    always_ff @(posedge clk) begin
        if (rst)                    r_cnt <= '0;
        else if (w_next != r_state) r_cnt <= '0;
        else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
    end

    // Operand shadows, result collection, flag and timeout capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_p        <= '0;
            r_mode     <= 1'b0;
            r_res_x1   <= '0;
            r_res_x2   <= '0;
            r_res_flag <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a        <= host.op_a;
                r_b        <= host.op_b;
                r_p        <= host.op_p;
                r_mode     <= host.mode;
                r_res_x1   <= '0;
                r_res_x2   <= '0;
                r_res_flag <= 1'b0;
                r_timeout  <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                if (eng_rdy) begin
                    r_res_flag <= eng_flag;
                end else if (r_cnt == WAIT_LAST) begin
                    r_timeout <= 1'b1;
                    r_res_x1  <= '0;
                    r_res_x2  <= '0;
                end
            end
            // Words arrive LS-first; shifting in from the top leaves word 0 at [WORD_W-1:0].
            if (r_state == S_READ && r_cnt >= CAP_FIRST) begin
                r_res_x1 <= {eng_x1, r_res_x1[OP_W-1:WORD_W]};
                r_res_x2 <= {eng_x2, r_res_x2[OP_W-1:WORD_W]};
            end
        end
    end

    assign eng_mode      = r_mode;
    assign host.busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign host.done     = (r_state == S_DONE);
    assign host.timeout  = r_timeout && (r_state == S_DONE);
    assign host.res_x1   = r_res_x1;
    assign host.res_x2   = r_res_x2;
    assign host.res_flag = r_res_flag;
    assign o_dbg_state   = r_state;
endmodule
